// File: rtl/cache_bank_sram.sv
// Single-port synchronous SRAM bank with per-lane write enables, a built-in clear
// sweep that zeroes every entry, and selectable read-during-write behaviour.
module cache_bank_sram #(
  parameter int unsigned        ADDR_W    = 8,
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        LANE_W    = 8,
  parameter int unsigned        WR_MODE   = 0,
  parameter bit                 INIT_CLR  = 1'b1,
  parameter logic [DATA_W-1:0]  CLR_VAL   = '0,
  parameter                     RAM_STYLE = "block"
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [DATA_W/LANE_W-1:0]   we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  input  logic                       clr_req,
  output logic                       busy
);

  localparam int unsigned LANES = DATA_W / LANE_W;
  localparam bit STYLE_OK = (RAM_STYLE == "block") || (RAM_STYLE == "distributed") ||
                            (RAM_STYLE == "registers") || (RAM_STYLE == "ultra");

  generate
    if ((DATA_W % LANE_W) != 0) begin : g_lane_chk
      $error("cache_bank_sram: DATA_W must be a multiple of LANE_W");
    end
    if (!STYLE_OK) begin : g_style_chk
      $error("cache_bank_sram: unsupported RAM_STYLE");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [LANES-1:0]    wr_lane;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   merged;
  logic                user_acc;

  (* ram_style = RAM_STYLE *) logic [DATA_W-1:0] mem [2**ADDR_W];

  assign user_acc = (state == ST_IDLE) && en;

  // Write port mux: the sweep owns the array while it runs; merged word feeds write-first.
  always_comb begin
    wr_lane = '0;
    wr_addr = addr;
    wr_data = din;
    rd_word = mem[addr];
    merged  = rd_word;
    for (int i = 0; i < int'(LANES); i++) begin
      if (we[i]) merged[i*LANE_W +: LANE_W] = din[i*LANE_W +: LANE_W];
    end
    if (state == ST_CLEAR) begin
      wr_lane = '1;
      wr_addr = cnt;
      wr_data = CLR_VAL;
    end else if (user_acc) begin
      wr_lane = we;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (wr_lane[i]) mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
    end
  end

  // Sweep FSM plus registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT_CLR ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
      busy  <= INIT_CLR;
      dout  <= '0;
    end else begin
      if (user_acc) begin
        if (we == '0)          dout <= rd_word;
        else if (WR_MODE != 0) dout <= merged;
      end
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == '1) state <= ST_DONE;
        end
        ST_DONE: begin
          // Extra cycle so the final cleared entry is readable before busy drops.
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bank_sram.sv
// Directed bench for cache_bank_sram: data bank (no-change), data bank (write-first)
// and a single-lane tag bank share one stimulus stream.
module tb_cache_bank_sram;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        clr_req;
  logic [3:0]  we;
  logic [0:0]  we_t;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout0, dout1;
  logic [20:0] dout_t;
  logic        busy0, busy1, busy_t;

  int n_chk  = 0;
  int n_pass = 0;
  int n;

  always #5 clk = ~clk;

  cache_bank_sram #(.ADDR_W(8), .DATA_W(32), .LANE_W(8), .WR_MODE(0)) u_nc (
    .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout0), .clr_req(clr_req), .busy(busy0));

  cache_bank_sram #(.ADDR_W(4), .DATA_W(32), .LANE_W(8), .WR_MODE(1)) u_wf (
    .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr[3:0]), .din(din),
    .dout(dout1), .clr_req(clr_req), .busy(busy1));

  cache_bank_sram #(.ADDR_W(8), .DATA_W(21), .LANE_W(21), .WR_MODE(0)) u_tag (
    .clk(clk), .reset(reset), .en(en), .we(we_t), .addr(addr), .din(din[20:0]),
    .dout(dout_t), .clr_req(clr_req), .busy(busy_t));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until busy0 falls, bounded so a stuck sweep cannot hang the run.
  task automatic wait_idle(inout int cnt);
    while (busy0 && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; clr_req = 1'b0; we = '0; we_t = '0; addr = '0; din = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_dout", dout0, 32'h0);
    check("rst_busy", 32'(busy0), 32'h1);
    repeat (3) tick();
    reset = 1'b0;
    n = 0;
    wait_idle(n);
    check("init_busy_len", 32'(n), 32'd257);

    en = 1'b1;
    addr = 8'h00; tick(); check("init_rd_00", dout0, 32'h0);
    addr = 8'h7F; tick(); check("init_rd_7f", dout0, 32'h0);
    addr = 8'hFF; tick(); check("init_rd_ff", dout0, 32'h0);

    // Lane merge
    addr = 8'h10; din = 32'hAABBCCDD; we = 4'hF; tick();
    din = 32'h11223344; we = 4'b0101; tick();
    check("wf_merged", dout1, 32'hAA22CC44);
    we = 4'h0; tick();
    check("lane_merge_rd", dout0, 32'hAA22CC44);

    // Read-during-write modes
    addr = 8'h05; din = 32'h0000_1234; we = 4'hF; tick();
    we = 4'h0; tick();
    check("rd_05", dout0, 32'h0000_1234);
    addr = 8'h09; din = 32'hCAFEF00D; we = 4'hF; tick();
    check("nochange_hold", dout0, 32'h0000_1234);
    check("writefirst", dout1, 32'hCAFEF00D);
    we = 4'h0; tick();
    check("rd_09", dout0, 32'hCAFEF00D);

    // Clear sweep on request; accesses and a second clr_req during busy are ignored
    addr = 8'h03; din = 32'hFFFF_FFFF; we = 4'hF; tick();
    en = 1'b0; we = 4'h0; clr_req = 1'b1; tick();
    clr_req = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      en = 1'b1; addr = 8'h03; din = 32'hFFFF_FFFF;
      we = ((i % 2) != 0) ? 4'hF : 4'h0;
      clr_req = (i == 10);
      tick();
      n++;
    end
    en = 1'b0; we = 4'h0; clr_req = 1'b0;
    check("busy_dout_frozen", dout0, 32'hCAFEF00D);
    wait_idle(n);
    check("clr_busy_len", 32'(n), 32'd257);
    en = 1'b1; addr = 8'h03; tick();
    check("clr_rd_03", dout0, 32'h0);

    // Reset in the middle of a sweep
    addr = 8'h20; din = 32'h5A5A5A5A; we = 4'hF; tick();
    we = 4'h0; tick();
    en = 1'b0; clr_req = 1'b1; tick();
    clr_req = 1'b0;
    repeat (100) tick();
    check("sweep_dout_hold", dout0, 32'h5A5A5A5A);
    reset = 1'b1;
    #1;
    check("async_rst_dout", dout0, 32'h0);
    tick(); tick();
    check("rst_busy_mid", 32'(busy0), 32'h1);
    reset = 1'b0;
    n = 0;
    wait_idle(n);
    check("restart_busy_len", 32'(n), 32'd257);

    // Tag bank: single full-width lane
    en = 1'b1; we = 4'h0; we_t = 1'b0; addr = 8'hFF; tick();
    check("tag_rd_cleared", 32'(dout_t), 32'h0);
    we_t = 1'b1; din = 32'h001F_FFFF; tick();
    we_t = 1'b0; tick();
    check("tag_rd", 32'(dout_t), 32'h001F_FFFF);
    en = 1'b0; addr = 8'h00; din = 32'h0;
    repeat (10) tick();
    check("tag_en0_hold", 32'(dout_t), 32'h001F_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
